// File: rtl/ssb_pkg.sv
// Shared definitions for the shared-system-bus arbiter: host indices,
// default widths, the per-host request bundle and the round-robin wrap helper.
package ssb_pkg;

  localparam int HostDbg   = 0;
  localparam int HostInstr = 1;
  localparam int HostData  = 2;

  localparam int DefNumHosts       = 3;
  localparam int DefMaxOutstanding = 2;
  localparam int DefAddrWidth      = 32;
  localparam int DefDataWidth      = 32;

  typedef struct packed {
    logic                        we;
    logic [DefDataWidth/8-1:0]   be;
    logic [DefAddrWidth-1:0]     addr;
    logic [DefDataWidth-1:0]     wdata;
  } ssb_req_t;

  // Next round-robin start point after granting host idx; host 0 never
  // takes part in the rotation, so the wrap goes back to the first
  // round-robin host rather than to 0.
  function automatic int rr_wrap(input int idx, input int num_hosts);
    if (idx >= num_hosts - 1) begin
      return HostInstr;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/ssb_id_fifo.sv
// In-order FIFO of host indices for transactions that were granted but not
// yet answered. A pop and a push in the same cycle are both honoured, even
// when full, because the pop frees the slot the push needs.
module ssb_id_fifo import ssb_pkg::*; #(
  parameter int Depth = DefMaxOutstanding,
  parameter int Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CntW'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards every stored ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/ssb_arbiter.sv
// Shared system bus arbiter: host 0 has strict priority, the remaining hosts
// rotate round-robin. An issued but ungranted request is locked to its host,
// and an ID FIFO routes each in-order response back to the host that issued it.
module ssb_arbiter import ssb_pkg::*; #(
  parameter int NumHosts       = DefNumHosts,
  parameter int MaxOutstanding = DefMaxOutstanding,
  parameter int AddrWidth      = DefAddrWidth,
  parameter int DataWidth      = DefDataWidth
) (
  input  logic                              clk_sys_i,
  input  logic                              rst_sys_i,
  input  logic [NumHosts-1:0]               host_req_i,
  input  logic [NumHosts-1:0]               host_we_i,
  input  logic [NumHosts*DataWidth/8-1:0]   host_be_i,
  input  logic [NumHosts*AddrWidth-1:0]     host_addr_i,
  input  logic [NumHosts*DataWidth-1:0]     host_wdata_i,
  output logic [NumHosts-1:0]               host_gnt_o,
  output logic [NumHosts-1:0]               host_rvalid_o,
  output logic [DataWidth-1:0]              host_rdata_o,
  output logic                              host_err_o,
  output logic                              dev_req_o,
  output logic                              dev_we_o,
  output logic [DataWidth/8-1:0]            dev_be_o,
  output logic [AddrWidth-1:0]              dev_addr_o,
  output logic [DataWidth-1:0]              dev_wdata_o,
  input  logic                              dev_gnt_i,
  input  logic                              dev_rvalid_i,
  input  logic [DataWidth-1:0]              dev_rdata_i,
  input  logic                              dev_err_i,
  output logic                              spurious_rvalid_o
);

  localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int BeW  = DataWidth / 8;

  logic [IdxW-1:0] rr_ptr;
  logic [IdxW-1:0] lock_idx;
  logic            locked;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] head;
  logic            have_win;
  logic            can_issue;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            spurious;

  // A response retiring this cycle frees a slot for a same-cycle issue.
  assign pop       = dev_rvalid_i && !fifo_empty && !rst_sys_i;
  assign can_issue = !fifo_full || pop;
  assign push      = have_win && dev_gnt_i && !rst_sys_i;

  // Winner selection: a locked host keeps the bus, else host 0, else round-robin.
  always_comb begin
    int              cand;
    logic [IdxW-1:0] cand_idx;
    sel      = '0;
    have_win = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (locked && !rst_sys_i) begin
      sel      = lock_idx;
      have_win = 1'b1;
    end else if (!can_issue) begin
      have_win = 1'b0;
    end else if (host_req_i[HostDbg]) begin
      sel      = IdxW'(HostDbg);
      have_win = 1'b1;
    end else begin
      for (int i = 0; i < NumHosts - 1; i++) begin
        cand     = ((int'(rr_ptr) - 1 + i) % (NumHosts - 1)) + 1;
        cand_idx = IdxW'(cand);
        if (!have_win && host_req_i[cand_idx]) begin
          sel      = cand_idx;
          have_win = 1'b1;
        end else begin
          have_win = have_win;
        end
      end
    end
  end

  // Forward the winner's request fields, zero when nobody is selected.
  always_comb begin
    dev_req_o   = have_win;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_addr_o  = '0;
    dev_wdata_o = '0;
    if (have_win) begin
      dev_we_o    = host_we_i[sel];
      dev_be_o    = host_be_i[int'(sel)*BeW +: BeW];
      dev_addr_o  = host_addr_i[int'(sel)*AddrWidth +: AddrWidth];
      dev_wdata_o = host_wdata_i[int'(sel)*DataWidth +: DataWidth];
    end else begin
      dev_we_o = 1'b0;
    end
  end

  // One-hot grant to the selected host and one-hot response to the FIFO head.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    if (push) begin
      host_gnt_o[sel] = 1'b1;
    end else begin
      host_gnt_o = '0;
    end
    if (pop) begin
      host_rvalid_o[head] = 1'b1;
    end else begin
      host_rvalid_o = '0;
    end
  end

  assign host_rdata_o      = dev_rdata_i;
  assign host_err_o        = dev_err_i;
  assign spurious_rvalid_o = spurious;

  // Lock, round-robin pointer and spurious-response flag state.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      locked   <= 1'b0;
      lock_idx <= '0;
      rr_ptr   <= IdxW'(HostInstr);
      spurious <= 1'b0;
    end else begin
      locked   <= have_win && !dev_gnt_i;
      lock_idx <= sel;
      if (push && (sel != IdxW'(HostDbg))) begin
        rr_ptr <= IdxW'(rr_wrap(int'(sel), NumHosts));
      end else begin
        rr_ptr <= rr_ptr;
      end
      spurious <= dev_rvalid_i && fifo_empty;
    end
  end

  ssb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk   (clk_sys_i),
    .rst   (rst_sys_i),
    .push  (push),
    .pop   (pop),
    .wdata (sel),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_ssb_arbiter.sv
// Randomized bench for ssb_arbiter: a transaction-level model predicts the
// winner every cycle and queues expected responses for a separate monitor.
module tb_ssb_arbiter;
  import ssb_pkg::*;

  localparam int NH = 3;
  localparam int MO = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NH-1:0]   host_req = '0;
  logic [NH-1:0]   host_we = '0;
  logic [NH*BW-1:0] host_be = '0;
  logic [NH*AW-1:0] host_addr = '0;
  logic [NH*DW-1:0] host_wdata = '0;
  logic [NH-1:0]   host_gnt;
  logic [NH-1:0]   host_rvalid;
  logic [DW-1:0]   host_rdata;
  logic            host_err;
  logic            dev_req, dev_we;
  logic [BW-1:0]   dev_be;
  logic [AW-1:0]   dev_addr;
  logic [DW-1:0]   dev_wdata;
  logic            dev_gnt = 1'b0;
  logic            dev_rvalid = 1'b0;
  logic [DW-1:0]   dev_rdata = '0;
  logic            dev_err = 1'b0;
  logic            spurious;

  always #5 clk = ~clk;

  ssb_arbiter #(.NumHosts(NH), .MaxOutstanding(MO), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
    .host_rdata_o(host_rdata), .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_be_o(dev_be),
    .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata),
    .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
    .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
    .spurious_rvalid_o(spurious)
  );

  typedef struct {
    int          host;
    logic [DW-1:0] data;
    logic        err;
  } resp_t;

  int       tests = 0;
  int       fails = 0;
  int       cyc = 0;
  resp_t    sb_q[$];
  int       spur_q[$];
  int       out_q[$];
  ssb_req_t hreq [NH];
  bit       active [NH];
  int       rr = 1;
  int       lock_host = -1;
  int       p_gnt = 60;
  int       p_rv = 40;
  int       p_new = 45;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: spurious flag every cycle, responses whenever a host sees rvalid.
  resp_t    mon_r;
  bit       mon_sp;
  logic [NH-1:0] mon_oh;
  always @(negedge clk) begin
    while (spur_q.size() > 0 && spur_q[0] < cyc) void'(spur_q.pop_front());
    if (!rst) begin
      mon_sp = (spur_q.size() > 0 && spur_q[0] == cyc);
      if (mon_sp) void'(spur_q.pop_front());
      chk("spurious", 64'(spurious), 64'(mon_sp));
      if (host_rvalid != '0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rvalid", 64'(host_rvalid), 64'd0);
        end else begin
          mon_r  = sb_q.pop_front();
          mon_oh = '0;
          mon_oh[mon_r.host] = 1'b1;
          chk("rvalid_route", 64'(host_rvalid), 64'(mon_oh));
          chk("rdata", 64'(host_rdata), 64'(mon_r.data));
          chk("err", 64'(host_err), 64'(mon_r.err));
        end
      end
    end
  end

  // One bus cycle: drive random stimulus, predict, compare, advance the model.
  task automatic step(input bit do_rst, input bit force_rv);
    int            w;
    int            h;
    bit            can;
    logic          gnt, rv, err;
    logic [DW-1:0] rdata;
    ssb_req_t      e;
    logic [NH-1:0] eg;
    @(posedge clk);
    #1;
    for (int i = 0; i < NH; i++) begin
      if (!active[i] && !do_rst && $urandom_range(99) < ((i == 0) ? 15 : p_new)) begin
        active[i]      = 1'b1;
        hreq[i].we     = 1'($urandom);
        hreq[i].be     = BW'($urandom);
        hreq[i].addr   = $urandom;
        hreq[i].wdata  = $urandom;
      end
    end
    gnt   = !do_rst && ($urandom_range(99) < p_gnt);
    rv    = !do_rst && (force_rv || ($urandom_range(99) < p_rv));
    rdata = $urandom;
    err   = ($urandom_range(9) == 0);
    rst = do_rst;
    for (int i = 0; i < NH; i++) begin
      host_req[i]             = active[i] && !do_rst;
      host_we[i]              = hreq[i].we;
      host_be[i*BW +: BW]     = hreq[i].be;
      host_addr[i*AW +: AW]   = hreq[i].addr;
      host_wdata[i*DW +: DW]  = hreq[i].wdata;
    end
    dev_gnt = gnt; dev_rvalid = rv; dev_rdata = rdata; dev_err = err;

    // Expected winner from the arbitration rules.
    can = (out_q.size() < MO) || (rv && out_q.size() > 0);
    w = -1;
    if (do_rst) begin
      w = -1;
    end else if (lock_host >= 0) begin
      w = lock_host;
    end else if (can) begin
      if (active[0]) begin
        w = 0;
      end else begin
        for (int i = 0; i < NH - 1; i++) begin
          h = ((rr - 1 + i) % (NH - 1)) + 1;
          if (w < 0 && active[h]) w = h;
        end
      end
    end
    e  = '0;
    eg = '0;
    if (w >= 0) e = hreq[w];
    if (w >= 0 && gnt) eg[w] = 1'b1;

    #1;
    chk("dev_req", 64'(dev_req), 64'(w >= 0));
    chk("dev_addr", 64'(dev_addr), 64'(e.addr));
    chk("dev_wdata", 64'(dev_wdata), 64'(e.wdata));
    chk("dev_we_be", 64'({dev_we, dev_be}), 64'({e.we, e.be}));
    chk("host_gnt", 64'(host_gnt), 64'(eg));
    if (do_rst) chk("rvalid_in_reset", 64'(host_rvalid), 64'd0);

    if (do_rst) begin
      out_q.delete();
      lock_host = -1;
      rr = 1;
    end else begin
      if (rv) begin
        if (out_q.size() > 0) begin
          h = out_q.pop_front();
          sb_q.push_back('{h, rdata, err});
        end else begin
          spur_q.push_back(cyc + 1);
        end
      end
      if (w >= 0 && gnt) begin
        out_q.push_back(w);
        active[w] = 1'b0;
        lock_host = -1;
        if (w != 0) rr = (w == NH - 1) ? 1 : w + 1;
      end else if (w >= 0) begin
        lock_host = w;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NH; i++) begin
      hreq[i]   = '0;
      active[i] = 1'b0;
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2;
    chk("reset_spurious", 64'(spurious), 64'd0);

    // Balanced traffic.
    for (int n = 0; n < 400; n++) step(1'b0, 1'b0);
    // Device grants eagerly, responds slowly: hits the outstanding limit.
    p_gnt = 90; p_rv = 15; p_new = 80;
    for (int n = 0; n < 300; n++) step(1'b0, 1'b0);
    // Reset with transactions likely outstanding, then an orphaned response.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    // Sluggish grants, frequent responses (many spurious ones).
    p_gnt = 30; p_rv = 60; p_new = 45;
    for (int n = 0; n < 300; n++) step(1'b0, 1'b0);
    p_gnt = 60; p_rv = 40;
    for (int n = 0; n < 300; n++) step(1'b0, 1'b0);

    @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
